// File: rtl/contador_bcd_mod_if.sv
// -----------------------------------------------------------------------------
// contador_bcd_mod_if
// Groups the control inputs and display outputs of one contador_bcd_mod stage.
// The clock and reset stay plain ports on the counter itself.
//   tick      count-enable pulse          load_val  7-bit binary load value
//   hold      freeze counter + prescaler  carry     one-cycle wrap pulse
//   clear     synchronous clear to 0      tens      BCD tens digit
//   up        1 = up, 0 = down            units     BCD units digit
//   load      synchronous load            seg_units units 7-seg, bit0=a..bit6=g
//                                         seg_tens  tens 7-seg, bit0=a..bit6=g
// master: the controller (or previous stage); slave: the counter.
// -----------------------------------------------------------------------------
interface contador_bcd_mod_if;
    logic       tick;
    logic       hold;
    logic       clear;
    logic       up;
    logic       load;
    logic [6:0] load_val;
    logic       carry;
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] seg_units;
    logic [6:0] seg_tens;

    modport master (
        output tick, hold, clear, up, load, load_val,
        input  carry, tens, units, seg_units, seg_tens
    );

    modport slave (
        input  tick, hold, clear, up, load, load_val,
        output carry, tens, units, seg_units, seg_tens
    );
endinterface

// File: rtl/contador_bcd_mod.sv
// -----------------------------------------------------------------------------
// contador_bcd_mod
// Modulo-MODULO two-digit BCD counter with a tick prescaler, up/down counting,
// synchronous clear/load, hold, a registered wrap carry and registered
// 7-segment outputs. Stages chain by feeding carry into the next tick.
// Ports:
//   clock   system clock, rising edge
//   ZERA_n  asynchronous active-low reset
//   bus     contador_bcd_mod_if.slave (controls in, digits/segments/carry out)
// Priority each edge: clear > load > hold > tick step.
// -----------------------------------------------------------------------------
module contador_bcd_mod #(
    parameter int MODULO         = 24,   // 2..100
    parameter int TICK_DIV       = 1,    // 1..65535
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEAD     = 1'b0
) (
    input  logic              clock,
    input  logic              ZERA_n,
    contador_bcd_mod_if.slave bus
);

    localparam logic [3:0]  MAX_TENS   = 4'((MODULO - 1) / 10);
    localparam logic [3:0]  MAX_UNITS  = 4'((MODULO - 1) % 10);
    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [6:0]  SEG_DARK   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Glyph table is stored active-low (bit6..0 = g..a) and inverted for
    // active-high boards; unused codes decode to dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] v_glyph;
        case (digit)
            4'd0:    v_glyph = 7'h40;
            4'd1:    v_glyph = 7'h79;
            4'd2:    v_glyph = 7'h24;
            4'd3:    v_glyph = 7'h30;
            4'd4:    v_glyph = 7'h19;
            4'd5:    v_glyph = 7'h12;
            4'd6:    v_glyph = 7'h02;
            4'd7:    v_glyph = 7'h78;
            4'd8:    v_glyph = 7'h00;
            4'd9:    v_glyph = 7'h10;
            default: v_glyph = 7'h7F;
        endcase
        return SEG_ACTIVE_LOW ? v_glyph : ~v_glyph;
    endfunction

    logic [3:0]  r_tens, r_units;
    logic [15:0] r_presc;
    logic        r_carry;
    logic [6:0]  r_seg_units, r_seg_tens;

    logic [3:0]  w_tens_nx, w_units_nx;
    logic [15:0] w_presc_nx;
    logic        w_carry_nx;
    logic        w_load_ok;
    logic [3:0]  w_load_tens, w_load_units;

    // Only the load path needs binary-to-BCD; the count itself stays in BCD.
    assign w_load_ok    = int'(bus.load_val) < MODULO;
    assign w_load_tens  = 4'(bus.load_val / 7'd10);
    assign w_load_units = 4'(bus.load_val % 7'd10);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and a latch can never be inferred.
        w_tens_nx  = r_tens;
        w_units_nx = r_units;
        w_presc_nx = r_presc;
        w_carry_nx = 1'b0;

        if (bus.clear) begin
            w_tens_nx  = 4'd0;
            w_units_nx = 4'd0;
            w_presc_nx = 16'd0;
        end else if (bus.load) begin
            // Out-of-range loads are dropped entirely, prescaler included.
            if (w_load_ok) begin
                w_tens_nx  = w_load_tens;
                w_units_nx = w_load_units;
                w_presc_nx = 16'd0;
            end
        end else if (!bus.hold && bus.tick) begin
            if (r_presc != PRESC_LAST) begin
                w_presc_nx = r_presc + 16'd1;
            end else begin
                w_presc_nx = 16'd0;
                if (bus.up) begin
                    if (r_tens == MAX_TENS && r_units == MAX_UNITS) begin
                        w_tens_nx  = 4'd0;
                        w_units_nx = 4'd0;
                        w_carry_nx = 1'b1;
                    end else if (r_units == 4'd9) begin
                        w_units_nx = 4'd0;
                        w_tens_nx  = r_tens + 4'd1;
                    end else begin
                        w_units_nx = r_units + 4'd1;
                    end
                end else begin
                    if (r_tens == 4'd0 && r_units == 4'd0) begin
                        w_tens_nx  = MAX_TENS;
                        w_units_nx = MAX_UNITS;
                        w_carry_nx = 1'b1;
                    end else if (r_units == 4'd0) begin
                        w_units_nx = 4'd9;
                        w_tens_nx  = r_tens - 4'd1;
                    end else begin
                        w_units_nx = r_units - 4'd1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge ZERA_n) begin
        if (!ZERA_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_presc <= 16'd0;
            r_carry <= 1'b0;
        end else begin
            r_tens  <= w_tens_nx;
            r_units <= w_units_nx;
            r_presc <= w_presc_nx;
            r_carry <= w_carry_nx;
        end
    end

    // Segments follow the registered digits one cycle later.
    always_ff @(posedge clock or negedge ZERA_n) begin
        if (!ZERA_n) begin
            r_seg_units <= seg_encode(4'd0);
            r_seg_tens  <= BLANK_LEAD ? SEG_DARK : seg_encode(4'd0);
        end else begin
            r_seg_units <= seg_encode(r_units);
            r_seg_tens  <= (BLANK_LEAD && r_tens == 4'd0) ? SEG_DARK
                                                          : seg_encode(r_tens);
        end
    end

    assign bus.carry     = r_carry;
    assign bus.tens      = r_tens;
    assign bus.units     = r_units;
    assign bus.seg_units = r_seg_units;
    assign bus.seg_tens  = r_seg_tens;

endmodule

// File: tb/tb_contador_bcd_mod.sv
// -----------------------------------------------------------------------------
// tb_contador_bcd_mod
// Three counter instances with different parameter sets share one stimulus
// stream. A reference model holds each counter as a plain integer value and
// derives digits, carry and glyphs from it with arithmetic.
//   A: MODULO=24  TICK_DIV=1 active-low  no blanking
//   B: MODULO=60  TICK_DIV=3 active-low  leading blank
//   C: MODULO=100 TICK_DIV=2 active-high leading blank
// -----------------------------------------------------------------------------
module tb_contador_bcd_mod;

    logic clock;
    logic ZERA_n;

    contador_bcd_mod_if ifa ();
    contador_bcd_mod_if ifb ();
    contador_bcd_mod_if ifc ();

    contador_bcd_mod #(.MODULO(24),  .TICK_DIV(1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b0))
        dut_a (.clock(clock), .ZERA_n(ZERA_n), .bus(ifa));
    contador_bcd_mod #(.MODULO(60),  .TICK_DIV(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b1))
        dut_b (.clock(clock), .ZERA_n(ZERA_n), .bus(ifb));
    contador_bcd_mod #(.MODULO(100), .TICK_DIV(2), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD(1'b1))
        dut_c (.clock(clock), .ZERA_n(ZERA_n), .bus(ifc));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int mod_p [3] = '{24, 60, 100};
    int div_p [3] = '{1, 3, 2};
    bit sal_p [3] = '{1'b1, 1'b1, 1'b0};
    bit bl_p  [3] = '{1'b0, 1'b1, 1'b1};

    logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         m_val   [3];
    int         m_pre   [3];
    logic       m_carry [3];
    logic [6:0] m_seg_u [3];
    logic [6:0] m_seg_t [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input int k, input int d);
        logic [6:0] g;
        g = glyph_tab[d];
        return sal_p[k] ? g : ~g;
    endfunction

    function automatic logic [6:0] dark(input int k);
        return sal_p[k] ? 7'h7F : 7'h00;
    endfunction

    function automatic logic [6:0] tens_glyph(input int k, input int v);
        if (bl_p[k] && v / 10 == 0) return dark(k);
        return enc(k, v / 10);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_val[k]   = 0;
            m_pre[k]   = 0;
            m_carry[k] = 1'b0;
            m_seg_u[k] = enc(k, 0);
            m_seg_t[k] = tens_glyph(k, 0);
        end
    endtask

    task automatic model_edge(input bit t, input bit h, input bit c, input bit u,
                              input bit l, input int lv);
        for (int k = 0; k < 3; k++) begin
            m_seg_u[k] = enc(k, m_val[k] % 10);
            m_seg_t[k] = tens_glyph(k, m_val[k]);
            m_carry[k] = 1'b0;
            if (c) begin
                m_val[k] = 0;
                m_pre[k] = 0;
            end else if (l) begin
                if (lv < mod_p[k]) begin
                    m_val[k] = lv;
                    m_pre[k] = 0;
                end
            end else if (!h && t) begin
                if (m_pre[k] == div_p[k] - 1) begin
                    m_pre[k] = 0;
                    if (u) begin
                        if (m_val[k] == mod_p[k] - 1) begin
                            m_val[k] = 0;
                            m_carry[k] = 1'b1;
                        end else m_val[k]++;
                    end else begin
                        if (m_val[k] == 0) begin
                            m_val[k] = mod_p[k] - 1;
                            m_carry[k] = 1'b1;
                        end else m_val[k]--;
                    end
                end else m_pre[k]++;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [3:0] tens, input logic [3:0] units,
                             input logic carry, input logic [6:0] su, input logic [6:0] st);
        string n;
        n = (k == 0) ? "A" : (k == 1) ? "B" : "C";
        check({n, ".tens"},  tens,  m_val[k] / 10);
        check({n, ".units"}, units, m_val[k] % 10);
        check({n, ".carry"}, carry, m_carry[k]);
        check({n, ".seg_u"}, su,    m_seg_u[k]);
        check({n, ".seg_t"}, st,    m_seg_t[k]);
    endtask

    task automatic check_all();
        check_dut(0, ifa.tens, ifa.units, ifa.carry, ifa.seg_units, ifa.seg_tens);
        check_dut(1, ifb.tens, ifb.units, ifb.carry, ifb.seg_units, ifb.seg_tens);
        check_dut(2, ifc.tens, ifc.units, ifc.carry, ifc.seg_units, ifc.seg_tens);
    endtask

    task automatic drive(input bit t, input bit h, input bit c, input bit u,
                         input bit l, input logic [6:0] lv);
        ifa.tick = t; ifa.hold = h; ifa.clear = c; ifa.up = u; ifa.load = l; ifa.load_val = lv;
        ifb.tick = t; ifb.hold = h; ifb.clear = c; ifb.up = u; ifb.load = l; ifb.load_val = lv;
        ifc.tick = t; ifc.hold = h; ifc.clear = c; ifc.up = u; ifc.load = l; ifc.load_val = lv;
    endtask

    // Drive, take one rising edge, advance the model, check 1 time unit later.
    task automatic step_cycle(input bit t, input bit h, input bit c, input bit u,
                              input bit l, input logic [6:0] lv);
        drive(t, h, c, u, l, lv);
        @(posedge clock);
        model_edge(t, h, c, u, l, int'(lv));
        #1;
        check_all();
    endtask

    initial begin
        ZERA_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        model_reset();
        #12;
        check_all();
        check("rst.A.seg_t", ifa.seg_tens, 7'h40);
        check("rst.B.seg_t", ifb.seg_tens, 7'h7F);
        ZERA_n = 1'b1;

        // Free-running up count from reset, tick held high.
        for (int i = 1; i <= 26; i++) begin
            step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
            if (i == 23) check("T1.seg_after_22", ifa.seg_units, 7'h24);
            if (i == 24) begin
                check("T1.wrap_tens",  ifa.tens,  4'd0);
                check("T1.wrap_units", ifa.units, 4'd0);
                check("T1.wrap_carry", ifa.carry, 1'b1);
            end
        end

        // Down count from 0 wraps to 23 with carry, then 22 without.
        step_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        check("T2.down_wrap_val", {ifa.tens, ifa.units}, 8'h23);
        check("T2.down_wrap_cy",  ifa.carry, 1'b1);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        check("T2.down_next_val", {ifa.tens, ifa.units}, 8'h22);
        check("T2.down_next_cy",  ifa.carry, 1'b0);

        // Load in range, then an out-of-range load that must be ignored.
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd17);
        check("T3.load17", {ifa.tens, ifa.units}, 8'h17);
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd30);
        check("T3.load30_ignored", {ifa.tens, ifa.units}, 8'h17);

        // Prescaler on B: 7 pulses -> 2, hold drops 5 ticks, prescaler kept.
        step_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 7; i++) begin
            step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
            step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        end
        check("T4.div3_val", {ifb.tens, ifb.units}, 8'h02);
        for (int i = 0; i < 5; i++) step_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0);
        check("T4.hold_val", {ifb.tens, ifb.units}, 8'h02);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        check("T4.presc_kept_a", {ifb.tens, ifb.units}, 8'h02);
        step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        check("T4.presc_kept_b", {ifb.tens, ifb.units}, 8'h03);

        // Clear beats load.
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd12);
        step_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7'd5);
        check("T5.clear_wins", {ifa.tens, ifa.units}, 8'h00);
        check("T5.clear_carry", ifa.carry, 1'b0);

        // Asynchronous reset mid-count at 19.
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd19);
        step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        #2;
        ZERA_n = 1'b0;
        model_reset();
        #1;
        check("T6.rst_val",   {ifa.tens, ifa.units}, 8'h00);
        check("T6.rst_seg_u", ifa.seg_units, 7'h40);
        check("T6.rst_seg_t", ifa.seg_tens,  7'h40);
        check("T6.rst_blank", ifb.seg_tens,  7'h7F);
        check_all();
        #2;
        ZERA_n = 1'b1;
        for (int i = 0; i < 5; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        check("T6.resume", {ifa.tens, ifa.units}, 8'h05);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit t, h, c, u, l;
            logic [6:0] lv;
            t  = ($urandom_range(0, 99) < 70);
            h  = ($urandom_range(0, 99) < 10);
            c  = ($urandom_range(0, 99) < 3);
            l  = ($urandom_range(0, 99) < 6);
            u  = ($urandom_range(0, 99) < 60);
            lv = 7'($urandom_range(0, 127));
            step_cycle(t, h, c, u, l, lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
